hwpf_req_arbiter: RTL and testbench

// - Shares the single hpdcache prefetch request port between N_REQ prefetch engines (next-line, stride, ...).
// - Round-robin grant, drops lines issued recently, enforces a minimum gap between issued prefetches.
// - Sits between the prefetch engines and the dcache request arbiter.
// - Output is registered and held stable until accepted.

---
 rtl/hwpf_pkg.sv | 25 ++
 rtl/hwpf_line_filter.sv | 65 ++++++
 rtl/hwpf_req_arbiter.sv | 148 ++++++++++++++
 tb/tb_hwpf_req_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hwpf_pkg.sv
// Shared types for the hardware prefetch request path.
// Covers the address type, the dcache request struct and line-address helpers.
package hwpf_pkg;

  localparam int unsigned HWPF_ADDR_W    = 32;
  localparam int unsigned HWPF_N_REQ_DEF = 2;
  localparam int unsigned HWPF_SRC_W     = $clog2(HWPF_N_REQ_DEF);

  typedef logic [HWPF_ADDR_W-1:0] addr_t;
  typedef logic [HWPF_ADDR_W-1:0] hwpf_line_addr_t;

  typedef struct packed {
    addr_t      addr;
    logic       uncacheable;
    logic [1:0] sid;
    logic [1:0] tid;
    logic       need_rsp;
  } hpdcache_req_t;

  // Line address = byte address with the line offset stripped.
  function automatic hwpf_line_addr_t line_addr(input addr_t addr, input int unsigned off_w);
    return hwpf_line_addr_t'(addr >> off_w);
  endfunction

endpackage

// File: rtl/hwpf_line_filter.sv
// Small CAM of recently issued line addresses with FIFO replacement.
// Filters out prefetches to lines that were just issued.
module hwpf_line_filter
  import hwpf_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  hwpf_line_addr_t lookup_i,
  output logic            hit_o,
  input  logic            insert_i,
  input  hwpf_line_addr_t insert_line_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic            [DEPTH-1:0] valid_q, valid_d;
  hwpf_line_addr_t [DEPTH-1:0] line_q, line_d;
  logic            [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  // Associative lookup over all valid entries.
  always_comb begin
    hit_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (line_q[i] == lookup_i)) begin
        hit_o = 1'b1;
      end else begin
        hit_o = hit_o;
      end
    end
  end

  // Insert at the write pointer, overwriting the oldest entry when full.
  always_comb begin
    valid_d  = valid_q;
    line_d   = line_q;
    wr_ptr_d = wr_ptr_q;
    if (flush_i) begin
      valid_d  = '0;
      wr_ptr_d = '0;
    end else if (insert_i) begin
      valid_d[wr_ptr_q] = 1'b1;
      line_d[wr_ptr_q]  = insert_line_i;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Filter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      line_q   <= '0;
      wr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      line_q   <= line_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule

// File: rtl/hwpf_req_arbiter.sv
// Round-robin arbiter sharing the dcache prefetch port between prefetch engines,
// with a recent-line filter and an optional minimum gap between issued requests.
module hwpf_req_arbiter
  import hwpf_pkg::*;
#(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned LINE_SIZE    = 64,
  parameter int unsigned FILTER_DEPTH = 8,
  parameter int unsigned MIN_GAP      = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     lock_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  addr_t [N_REQ-1:0]        req_addr_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic                     arb_valid_o,
  input  logic                     arb_ready_i,
  output hpdcache_req_t            arb_req_o,
  output logic [$clog2(N_REQ)-1:0] arb_src_o,
  output logic                     drop_o
);

  localparam int unsigned SRC_W = $clog2(N_REQ);
  localparam int unsigned OFF_W = $clog2(LINE_SIZE);
  localparam int unsigned GAP_W = $clog2(MIN_GAP + 2);

  logic            valid_q, valid_d;
  hpdcache_req_t   req_q, req_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic            drop_q, drop_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             can_grant_s;
  logic             grant_found_s;
  logic             grant_s;
  logic [SRC_W-1:0] grant_idx_s;
  logic [SRC_W-1:0] cand_s;
  hwpf_line_addr_t  sel_line_s;
  logic             hit_s;
  logic             insert_s;

  assign can_grant_s = ~flush_i & ~lock_i & (gap_q == '0) & (~valid_q | arb_ready_i);
  assign grant_s     = can_grant_s & grant_found_s;
  assign sel_line_s  = line_addr(req_addr_i[grant_idx_s], OFF_W);

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand_s = SRC_W'((32'(rr_ptr_q) + k) % N_REQ);
      if (!grant_found_s && req_valid_i[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // One-hot consume strobe back to the granted engine.
  always_comb begin
    req_ready_o = '0;
    if (grant_s) begin
      req_ready_o[grant_idx_s] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
  end

  hwpf_line_filter #(
    .DEPTH(FILTER_DEPTH)
  ) u_filter (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .lookup_i     (sel_line_s),
    .hit_o        (hit_s),
    .insert_i     (insert_s),
    .insert_line_i(sel_line_s)
  );

  // Output slot, drop pulse, gap counter and RR pointer next state.
  always_comb begin
    valid_d  = valid_q;
    req_d    = req_q;
    src_d    = src_q;
    drop_d   = 1'b0;
    gap_d    = gap_q;
    rr_ptr_d = rr_ptr_q;
    insert_s = 1'b0;
    if (flush_i) begin
      valid_d  = 1'b0;
      gap_d    = '0;
      rr_ptr_d = '0;
    end else begin
      gap_d   = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
      valid_d = (valid_q && arb_ready_i) ? 1'b0 : valid_q;
      if (grant_s) begin
        rr_ptr_d = (grant_idx_s == SRC_W'(N_REQ - 1)) ? '0 : grant_idx_s + SRC_W'(1);
        if (hit_s) begin
          drop_d = 1'b1;
        end else begin
          valid_d           = 1'b1;
          req_d.addr        = addr_t'(sel_line_s << OFF_W);
          req_d.uncacheable = 1'b0;
          req_d.sid         = 2'b00;
          req_d.tid         = 2'b00;
          req_d.need_rsp    = 1'b0;
          src_d             = grant_idx_s;
          gap_d             = GAP_W'(MIN_GAP);
          insert_s          = 1'b1;
        end
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end
  end

  // Arbiter state registers; a reset drops any pending request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      req_q    <= '0;
      src_q    <= '0;
      drop_q   <= 1'b0;
      gap_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      req_q    <= req_d;
      src_q    <= src_d;
      drop_q   <= drop_d;
      gap_q    <= gap_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign arb_valid_o = valid_q;
  assign arb_req_o   = req_q;
  assign arb_src_o   = src_q;
  assign drop_o      = drop_q;

endmodule

// File: tb/tb_hwpf_req_arbiter.sv
// Self-checking bench for hwpf_req_arbiter: directed vector table, hand sequences
// for filter wrap and minimum gap, then random traffic against a queue-based model.
module tb_hwpf_req_arbiter;
  import hwpf_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          lock;
  logic [1:0]    rv;
  addr_t [1:0]   addr;
  logic          rdy;

  logic [1:0]    rdy0, rdy1;
  logic          v0, v1;
  hpdcache_req_t req0, req1;
  logic          src0, src1;
  logic          drop0, drop1;

  int n_cmp = 0;
  int n_bad = 0;

  hwpf_req_arbiter #(.N_REQ(2), .LINE_SIZE(64), .FILTER_DEPTH(8), .MIN_GAP(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .lock_i(lock),
    .req_valid_i(rv), .req_addr_i(addr), .req_ready_o(rdy0),
    .arb_valid_o(v0), .arb_ready_i(rdy), .arb_req_o(req0), .arb_src_o(src0), .drop_o(drop0)
  );

  hwpf_req_arbiter #(.N_REQ(2), .LINE_SIZE(64), .FILTER_DEPTH(8), .MIN_GAP(3)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .lock_i(lock),
    .req_valid_i(rv), .req_addr_i(addr), .req_ready_o(rdy1),
    .arb_valid_o(v1), .arb_ready_i(rdy), .arb_req_o(req1), .arb_src_o(src1), .drop_o(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        f;
    logic        l;
    logic [1:0]  v;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        rdy;
    logic [1:0]  e_rr;
    logic        e_v;
    logic [31:0] e_a;
    logic        e_s;
    logic        e_d;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic f, input logic l, input logic [1:0] v, input logic [31:0] a0,
                     input logic [31:0] a1, input logic r, input logic [1:0] e_rr, input logic e_v,
                     input logic [31:0] e_a, input logic e_s, input logic e_d);
    vec_t t;
    t = '{f, l, v, a0, a1, r, e_rr, e_v, e_a, e_s, e_d};
    tbl.push_back(t);
  endtask

  task automatic do_flush();
    flush = 1'b1; lock = 1'b0; rv = 2'b00; rdy = 1'b1;
    @(posedge clk); #1;
    chk("flush_valid0", 32'(v0), 32'd0);
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Engine 0 alone offers one address with the output port always ready.
  task automatic issue0(input logic [31:0] a, input logic exp_issue, input string nm);
    flush = 1'b0; lock = 1'b0; rv = 2'b01; addr[0] = a; rdy = 1'b1;
    #1;
    chk({nm, "_rdy"}, 32'(rdy0), 32'd1);
    @(posedge clk); #1;
    chk({nm, "_valid"}, 32'(v0), 32'(exp_issue));
    chk({nm, "_drop"}, 32'(drop0), 32'(!exp_issue));
    if (exp_issue) chk({nm, "_addr"}, req0.addr, a & 32'hffff_ffc0);
    @(negedge clk);
  endtask

  // Reference model state: output slot, drop pulse, RR pointer, FIFO of recent lines.
  logic        m_valid, m_drop, m_src;
  logic [31:0] m_addr;
  int          m_rr;
  logic [31:0] q_lines[$];

  initial begin
    int          exp_g;
    logic [1:0]  exp_rr;
    logic [31:0] line;
    logic        hit;
    int          grants1[$];
    int          n0;

    // Reset with lock asserted and both engines requesting.
    rst_n = 1'b0; flush = 1'b0; lock = 1'b1; rv = 2'b11; rdy = 1'b0;
    addr[0] = 32'h1000; addr[1] = 32'h1040;
    #3;
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_addr", req0.addr, 32'd0);
    chk("rst_src", 32'(src0), 32'd0);
    chk("rst_drop", 32'(drop0), 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lock_ready", 32'(rdy0), 32'd0);
      chk("lock_valid", 32'(v0), 32'd0);
      @(negedge clk);
    end

    //  f     l     v      a0          a1          rdy   e_rr   e_v   e_a         e_s   e_d
    add(1'b0, 1'b0, 2'b11, 32'h1000, 32'h1040, 1'b1, 2'b01, 1'b1, 32'h1000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'b11, 32'h1080, 32'h1040, 1'b1, 2'b10, 1'b1, 32'h1040, 1'b1, 1'b0);
    add(1'b0, 1'b0, 2'b11, 32'h1080, 32'h10c0, 1'b1, 2'b01, 1'b1, 32'h1080, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'b11, 32'h1100, 32'h10c0, 1'b1, 2'b10, 1'b1, 32'h10c0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 2'b01, 32'h2010, 32'h0000, 1'b1, 2'b01, 1'b1, 32'h2000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'b01, 32'h2030, 32'h0000, 1'b1, 2'b01, 1'b0, 32'h2000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 2'b00, 32'h0000, 32'h0000, 1'b1, 2'b00, 1'b0, 32'h2000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'b01, 32'h3000, 32'h0000, 1'b0, 2'b01, 1'b1, 32'h3000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b0, 2'b11, 32'h3040, 32'h3080, 1'b0, 2'b00, 1'b1, 32'h3000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'b11, 32'h3040, 32'h3080, 1'b1, 2'b10, 1'b1, 32'h3080, 1'b1, 1'b0);
    add(1'b0, 1'b0, 2'b00, 32'h0000, 32'h0000, 1'b1, 2'b00, 1'b0, 32'h3080, 1'b1, 1'b0);
    add(1'b0, 1'b0, 2'b01, 32'h4000, 32'h0000, 1'b0, 2'b01, 1'b1, 32'h4000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 2'b11, 32'h4040, 32'h5000, 1'b0, 2'b00, 1'b1, 32'h4000, 1'b0, 1'b0);
    add(1'b1, 1'b0, 2'b11, 32'h3000, 32'h5000, 1'b0, 2'b00, 1'b0, 32'h4000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'b01, 32'h3000, 32'h0000, 1'b1, 2'b01, 1'b1, 32'h3000, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      flush = tbl[i].f; lock = tbl[i].l; rv = tbl[i].v; rdy = tbl[i].rdy;
      addr[0] = tbl[i].a0; addr[1] = tbl[i].a1;
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(rdy0), 32'(tbl[i].e_rr));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_valid", i), 32'(v0), 32'(tbl[i].e_v));
      if (tbl[i].e_v) begin
        chk($sformatf("tbl%0d_addr", i), req0.addr, tbl[i].e_a);
        chk($sformatf("tbl%0d_src", i), 32'(src0), 32'(tbl[i].e_s));
      end
      chk($sformatf("tbl%0d_drop", i), 32'(drop0), 32'(tbl[i].e_d));
      @(negedge clk);
    end

    // Filter holds 8 lines: the 8th-newest still drops, one more insert evicts it.
    do_flush();
    issue0(32'h2000, 1'b1, "wrap_first");
    for (int i = 0; i < 7; i++) issue0(32'h6000 + 32'(i) * 32'h40, 1'b1, "wrap_fill");
    issue0(32'h2010, 1'b0, "wrap_still_hit");
    issue0(32'h6200, 1'b1, "wrap_evict");
    issue0(32'h2000, 1'b1, "wrap_reissue");

    // Continuous fresh lines: MIN_GAP=3 instance grants every 4th cycle.
    do_flush();
    n0 = 0;
    for (int c = 0; c < 20; c++) begin
      rv = 2'b01; rdy = 1'b1; addr[0] = 32'ha000 + 32'(c) * 32'h40;
      #1;
      if (rdy1[0]) grants1.push_back(c);
      if (rdy0[0]) n0++;
      @(negedge clk);
    end
    chk("gap_count", 32'(grants1.size()), 32'd5);
    foreach (grants1[k]) chk($sformatf("gap_slot%0d", k), 32'(grants1[k]), 32'(k * 4));
    chk("nogap_count", 32'(n0), 32'd20);

    // Random traffic against the model.
    do_flush();
    m_valid = 1'b0; m_drop = 1'b0; m_src = 1'b0; m_addr = 32'd0; m_rr = 0;
    q_lines.delete();
    for (int c = 0; c < 800; c++) begin
      flush = ($urandom_range(0, 31) == 0);
      lock  = ($urandom_range(0, 7) == 0);
      rv    = 2'($urandom_range(0, 3));
      rdy   = 1'($urandom_range(0, 1));
      for (int e = 0; e < 2; e++)
        addr[e] = 32'h9000 + 32'($urandom_range(0, 23)) * 32'h40 + 32'($urandom_range(0, 63));
      #1;
      exp_g = -1;
      if (!flush && !lock && (!m_valid || rdy)) begin
        for (int k = 0; k < 2; k++) begin
          if (exp_g < 0 && rv[(m_rr + k) % 2]) exp_g = (m_rr + k) % 2;
        end
      end
      exp_rr = (exp_g >= 0) ? (2'b01 << exp_g) : 2'b00;
      chk("rnd_ready", 32'(rdy0), 32'(exp_rr));
      chk("rnd_valid", 32'(v0), 32'(m_valid));
      if (m_valid) begin
        chk("rnd_addr", req0.addr, m_addr);
        chk("rnd_src", 32'(src0), 32'(m_src));
      end
      chk("rnd_drop", 32'(drop0), 32'(m_drop));
      if (flush) begin
        m_valid = 1'b0; m_drop = 1'b0; m_rr = 0;
        q_lines.delete();
      end else begin
        m_drop = 1'b0;
        if (m_valid && rdy) m_valid = 1'b0;
        if (exp_g >= 0) begin
          line = addr[exp_g] >> 6;
          hit  = 1'b0;
          foreach (q_lines[j]) if (q_lines[j] == line) hit = 1'b1;
          m_rr = (exp_g + 1) % 2;
          if (hit) begin
            m_drop = 1'b1;
          end else begin
            m_valid = 1'b1;
            m_addr  = line << 6;
            m_src   = 1'(exp_g);
            q_lines.push_back(line);
            if (q_lines.size() > 8) q_lines.delete(0);
          end
        end
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
